// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 2*XLEN accumulator, producing a HI/LO result pair.
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] input1,
    input  logic [XLEN-1:0] input2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);

    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]     LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] cond_neg_x(input logic [XLEN-1:0] v, input logic neg);
        logic [XLEN-1:0] r;
        if (neg) begin
            r = ~v + ONE_X;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_2x(input logic [2*XLEN-1:0] v, input logic neg);
        logic [2*XLEN-1:0] r;
        if (neg) begin
            r = ~v + ONE_2X;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [CW-1:0]     count_r;
    logic              op_div_r;
    logic [XLEN-1:0]   b_r;
    logic [2*XLEN-1:0] acc_r;
    logic              neg_q_r;
    logic              neg_rem_r;
    logic              dbz_pend_r;
    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic              dbz_r;
    logic              busy_r;
    logic              done_r;

    logic              accept_s;
    logic              in_signed_s;
    logic              in_div_s;
    logic [XLEN-1:0]   mag1_s;
    logic [XLEN-1:0]   mag2_s;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     div_trial_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [2*XLEN-1:0] div_next_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fin_hi_s;
    logic [XLEN-1:0]   fin_lo_s;

    assign busy        = busy_r;
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dbz_r;

    // Operand decode and magnitude extraction at the start edge.
    always_comb begin
        accept_s    = ((state_r == S_IDLE) || (state_r == S_DONE)) && start && !flush;
        in_signed_s = ~op[0];
        in_div_s    = op[1];
        mag1_s      = cond_neg_x(input1, in_signed_s & input1[XLEN-1]);
        mag2_s      = cond_neg_x(input2, in_signed_s & input2[XLEN-1]);
    end

    // One shift-add or restoring-divide step; the divide partial remainder
    // is XLEN+1 bits wide so the borrow bit signals a failed trial.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
        div_trial_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, b_r};
        div_ge_s    = ~div_trial_s[XLEN];
        if (div_ge_s) begin
            div_next_s = {div_trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            div_next_s = {acc_r[2*XLEN-2:XLEN-1], acc_r[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction of the finished magnitudes; a zero divisor forces an
    // all-ones quotient while the remainder path reproduces the dividend.
    always_comb begin
        prod_s = cond_neg_2x(acc_r, neg_q_r);
        rem_s  = cond_neg_x(acc_r[2*XLEN-1:XLEN], neg_rem_r);
        if (dbz_pend_r) begin
            quot_s = {XLEN{1'b1}};
        end else begin
            quot_s = cond_neg_x(acc_r[XLEN-1:0], neg_q_r);
        end
        if (op_div_r) begin
            fin_hi_s = rem_s;
            fin_lo_s = quot_s;
        end else begin
            fin_hi_s = prod_s[2*XLEN-1:XLEN];
            fin_lo_s = prod_s[XLEN-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_nxt_s = S_IDLE;
                end else if (count_r == LAST_CNT) begin
                    state_nxt_s = S_FIN;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_FIN: begin
                if (flush) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            S_DONE: begin
                if (accept_s) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_RUN) || (state_nxt_s == S_FIN);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (accept_s) begin
            count_r <= {CW{1'b0}};
        end else if ((state_r == S_RUN) && !flush) begin
            count_r <= (count_r == LAST_CNT) ? {CW{1'b0}} : count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Operand capture and accumulator iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_div_r   <= 1'b0;
            b_r        <= {XLEN{1'b0}};
            acc_r      <= {(2*XLEN){1'b0}};
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            dbz_pend_r <= 1'b0;
        end else if (accept_s) begin
            op_div_r   <= in_div_s;
            b_r        <= in_div_s ? mag2_s : mag1_s;
            acc_r      <= {{XLEN{1'b0}}, (in_div_s ? mag1_s : mag2_s)};
            neg_q_r    <= in_signed_s & (input1[XLEN-1] ^ input2[XLEN-1]);
            neg_rem_r  <= in_signed_s & input1[XLEN-1];
            dbz_pend_r <= in_div_s & (input2 == {XLEN{1'b0}});
        end else if ((state_r == S_RUN) && !flush) begin
            acc_r <= op_div_r ? div_next_s : mul_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Result registers only change in FIN, so partial values never escape.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r  <= {XLEN{1'b0}};
            lo_r  <= {XLEN{1'b0}};
            dbz_r <= 1'b0;
        end else if (accept_s) begin
            dbz_r <= 1'b0;
        end else if ((state_r == S_FIN) && !flush) begin
            hi_r  <= fin_hi_s;
            lo_r  <= fin_lo_s;
            dbz_r <= dbz_pend_r;
        end else begin
            hi_r  <= hi_r;
            lo_r  <= lo_r;
            dbz_r <= dbz_r;
        end
    end

endmodule
